wb_vmon_msg_sequencer: RTL and testbench

// - Shares the single Wishbone write path into the vmon mailbox among N_REQ byte-stream requesters.
// - Round-robin arbitration; a grant is held for a whole message (through req_last).
// - Packs each granted message's bytes into 32-bit Wishbone writes to ADDRESS.
// - Uses only SEL codes the vmon monitor decodes (4'b0001, 4'b0011, 4'b1111).
//

---
 rtl/wb_vmon_msg_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_wb_vmon_msg_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_vmon_msg_sequencer.sv
// wb_vmon_msg_sequencer
// Round-robin sequencer that lets N_REQ byte-stream requesters share one
// Wishbone write path into the vmon mailbox. A grant covers one whole
// message. Bytes are packed into 32-bit writes, using only SEL codes
// 0001, 0011 and 1111; a 3-byte group is split into 0011 + 0001 writes.
// Optional feature macro: WB_VMON_SEQ_TIMEOUT_EN turns on an ACK-wait
// timeout of TIMEOUT_CYCLES that takes the same path as ERR.
//
// Handshake: a requester byte moves when req_valid[i] & req_ready[i] are
// both high at a rising clk_i edge; req_ready is driven from registered
// state only, so it never depends combinationally on req_valid.
module wb_vmon_msg_sequencer #(
  parameter int                       N_REQ          = 2,
  parameter int                       WB_ADDR_WIDTH  = 32,
  parameter int                       WB_DATA_WIDTH  = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS        = '0,
  parameter int                       TIMEOUT_CYCLES = 256,
  localparam int                      GW             = $clog2(N_REQ) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WB_ADDR_WIDTH-1:0] ADR,
  output logic [WB_DATA_WIDTH-1:0] DAT_W,
  output logic [3:0]               SEL,
  output logic                     CYC,
  output logic                     STB,
  output logic                     WE,
  input  logic                     ACK,
  input  logic                     ERR,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     err_o,
  output logic [2:0]               state_o
);

  if (WB_DATA_WIDTH != 32) begin : g_bad_width
    $error("wb_vmon_msg_sequencer: WB_DATA_WIDTH must be 32");
  end
  if (N_REQ < 1 || N_REQ > 8) begin : g_bad_nreq
    $error("wb_vmon_msg_sequencer: N_REQ must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("wb_vmon_msg_sequencer: TIMEOUT_CYCLES must be >= 1");
  end

  // S_GAP is the idle bus cycle between the two halves of a 3-byte group.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_GAP     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [31:0]     buf_q, buf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            last_q, last_d;   // last byte of the message already taken
  logic            split_q, split_d; // second half of a 3-byte group pending
  logic [7:0]      pend_q, pend_d;   // byte 2 of a 3-byte group
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            err_q, err_d;
  logic            tmo_hit;

  logic            g_valid, g_last;
  logic [7:0]      g_data;
  logic [31:0]     buf_n;
  logic [2:0]      cnt_n;
  logic [GW-1:0]   pick;
  logic            found;
  int              idx;

`ifdef WB_VMON_SEQ_TIMEOUT_EN
  logic [31:0]     tmo_q, tmo_d;

  // ACK-wait counter: runs only while a write is on the bus.
  always_comb begin
    tmo_d   = '0;
    tmo_hit = (state_q == S_WRITE) && !ACK && !ERR &&
              (tmo_q == 32'(TIMEOUT_CYCLES - 1));
    if (state_q == S_WRITE && !ACK && !ERR && !tmo_hit) tmo_d = tmo_q + 32'd1;
  end

  // Timeout counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state logic: arbitration, byte packing and write sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    split_d = split_q;
    pend_d  = pend_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    pick    = '0;
    found   = 1'b0;
    idx     = 0;

    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end

    // First valid requester strictly after the rr pointer, wrapping.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          rr_d    = pick;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (g_valid) begin
          case (cnt_q)
            3'd0:    buf_n[7:0]   = g_data;
            3'd1:    buf_n[15:8]  = g_data;
            3'd2:    buf_n[23:16] = g_data;
            default: buf_n[31:24] = g_data;
          endcase
          cnt_n = cnt_q + 3'd1;
          if (g_last) last_d = 1'b1;
          if (cnt_n == 3'd4 || g_last) begin
            state_d = S_WRITE;
            buf_d   = '0;
            cnt_d   = '0;
            case (cnt_n)
              3'd1: begin
                dat_d = {24'h0, buf_n[7:0]};
                sel_d = 4'b0001;
              end
              3'd2: begin
                dat_d = {16'h0, buf_n[15:0]};
                sel_d = 4'b0011;
              end
              3'd3: begin
                dat_d   = {16'h0, buf_n[15:0]};
                sel_d   = 4'b0011;
                split_d = 1'b1;
                pend_d  = buf_n[23:16];
              end
              default: begin
                dat_d = buf_n;
                sel_d = 4'b1111;
              end
            endcase
          end else begin
            buf_d = buf_n;
            cnt_d = cnt_n;
          end
        end
      end
      S_WRITE: begin
        if (ERR || tmo_hit) begin
          err_d   = 1'b1;
          dat_d   = '0;
          sel_d   = '0;
          split_d = 1'b0;
          pend_d  = '0;
          last_d  = 1'b0;
          state_d = last_q ? S_IDLE : S_DRAIN;
        end else if (ACK) begin
          dat_d = '0;
          sel_d = '0;
          if (split_q) begin
            split_d = 1'b0;
            dat_d   = {24'h0, pend_q};
            sel_d   = 4'b0001;
            pend_d  = '0;
            state_d = S_GAP;
          end else if (last_q) begin
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_GAP: begin
        state_d = S_WRITE;
      end
      S_DRAIN: begin
        if (g_valid && g_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= GW'(N_REQ - 1);
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      split_q <= 1'b0;
      pend_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      split_q <= split_d;
      pend_q  <= pend_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // Requester ready: only the granted requester, only while taking bytes.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q == S_COLLECT || state_q == S_DRAIN) &&
                     (grant_q == GW'(i));
    end
  end

  assign CYC      = (state_q == S_WRITE);
  assign STB      = (state_q == S_WRITE);
  assign WE       = (state_q == S_WRITE);
  assign ADR      = ADDRESS;
  assign DAT_W    = dat_q;
  assign SEL      = sel_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);
  assign err_o    = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_wb_vmon_msg_sequencer.sv
// Testbench for wb_vmon_msg_sequencer (N_REQ=2).
// Requester drivers feed per-requester byte queues; a Wishbone slave model
// answers writes; a monitor compares every bus cycle against an expected
// write queue filled by the directed tests.
module tb_wb_vmon_msg_sequencer;

  localparam int          N_REQ = 2;
  localparam int          GW    = $clog2(N_REQ) + 1;
  localparam int          EW    = GW + 4 + 32;
  localparam logic [31:0] ADDR  = 32'h0000_1000;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data  = '0;
  logic [N_REQ-1:0]   req_last  = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [31:0]        ADR;
  logic [31:0]        DAT_W;
  logic [3:0]         SEL;
  logic               CYC, STB, WE;
  logic               ACK = 1'b0;
  logic               ERR = 1'b0;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               err_o;
  logic [2:0]         dbg_state;

  wb_vmon_msg_sequencer #(
    .N_REQ(N_REQ), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32),
    .ADDRESS(ADDR), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .ADR(ADR), .DAT_W(DAT_W), .SEL(SEL), .CYC(CYC), .STB(STB), .WE(WE),
    .ACK(ACK), .ERR(ERR),
    .grant_id(grant_id), .busy(busy), .err_o(err_o), .state_o(dbg_state)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic [8:0]    src0[$];
  logic [8:0]    src1[$];
  logic          take0 = 1'b0;
  logic          take1 = 1'b0;

  // Slave controls.
  int   ack_wait = 0;
  logic ack_en   = 1'b1;
  logic err_next = 1'b0;
  int   wait_cnt = 0;

  // Monitor state.
  logic in_cyc       = 1'b0;
  int   cyc_len      = 0;
  int   last_cyc_len = 0;
  int   err_seen     = 0;

  function automatic logic [EW-1:0] mk(input logic [GW-1:0] g, input logic [3:0] s,
                                       input logic [31:0] d);
    return {g, s, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input logic last);
    if (r == 0) src0.push_back({last, b});
    else        src1.push_back({last, b});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 500 && !(busy == 1'b0 && !CYC && src0.size() == 0 &&
                        src1.size() == 0 && exp_q.size() == 0)) begin
      @(negedge clk_i);
      n++;
    end
    chk({name, "_idle_reached"}, 64'(n < 500), 64'd1);
    repeat (2) @(negedge clk_i);
  endtask

  // Requester drivers: pop bytes accepted at the previous edge, present next.
  always @(negedge clk_i) begin
    if (take0) void'(src0.pop_front());
    if (take1) void'(src1.pop_front());
    if (src0.size() > 0) begin
      req_valid[0] = 1'b1; req_data[7:0] = src0[0][7:0]; req_last[0] = src0[0][8];
    end else begin
      req_valid[0] = 1'b0; req_data[7:0] = 8'h0; req_last[0] = 1'b0;
    end
    if (src1.size() > 0) begin
      req_valid[1] = 1'b1; req_data[15:8] = src1[0][7:0]; req_last[1] = src1[0][8];
    end else begin
      req_valid[1] = 1'b0; req_data[15:8] = 8'h0; req_last[1] = 1'b0;
    end
    take0 = req_valid[0] && req_ready[0];
    take1 = req_valid[1] && req_ready[1];
  end

  // Slave model plus scoreboard monitor.
  always @(negedge clk_i) begin
    logic [EW-1:0] got, front;
    ACK = 1'b0;
    ERR = 1'b0;
    if (err_o) err_seen++;
    if (CYC) begin
      if (STB && wait_cnt >= ack_wait) begin
        if (err_next) begin
          ERR      = 1'b1;
          err_next = 1'b0;
        end else if (ack_en) begin
          ACK = 1'b1;
        end
      end
      wait_cnt++;
      cyc_len++;
      in_cyc = 1'b1;
      got = mk(grant_id, SEL, DAT_W);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got grant=%0d sel=%b dat=%h, expected no write",
                 grant_id, SEL, DAT_W);
      end else begin
        front = exp_q[0];
        if (got !== front || ADR !== ADDR || WE !== 1'b1 || STB !== 1'b1) begin
          n_fail++;
          $display("FAIL wb_write: got grant=%0d sel=%b dat=%h adr=%h we=%b stb=%b, expected grant=%0d sel=%b dat=%h adr=%h we=1 stb=1",
                   grant_id, SEL, DAT_W, ADR, WE, STB,
                   front[EW-1 -: GW], front[35:32], front[31:0], ADDR);
        end
      end
    end else begin
      wait_cnt = 0;
      if (in_cyc) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_cyc_len = cyc_len;
      end
      in_cyc  = 1'b0;
      cyc_len = 0;
    end
  end

  initial begin
    // Reset state.
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_cyc",       64'(CYC),       64'd0);
    chk("rst_stb",       64'(STB),       64'd0);
    chk("rst_we",        64'(WE),        64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_err_o",     64'(err_o),     64'd0);
    chk("rst_sel",       64'(SEL),       64'd0);
    chk("rst_dat_w",     64'(DAT_W),     64'd0);
    chk("rst_adr",       64'(ADR),       64'(ADDR));
    chk("rst_grant_id",  64'(grant_id),  64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Full word from requester 0.
    exp_q.push_back(mk(0, 4'b1111, 32'h44332211));
    push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0);
    push_byte(0, 8'h33, 0); push_byte(0, 8'h44, 1);
    wait_idle("word4");

    // 3-byte message splits into 0011 + 0001.
    exp_q.push_back(mk(0, 4'b0011, 32'h0000BBAA));
    exp_q.push_back(mk(0, 4'b0001, 32'h000000CC));
    push_byte(0, 8'hAA, 0); push_byte(0, 8'hBB, 0); push_byte(0, 8'hCC, 1);
    wait_idle("split3");

    // Round-robin from a fresh reset, both requesters contending.
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.push_back(mk(0, 4'b0011, 32'h00000201));
    exp_q.push_back(mk(1, 4'b1111, 32'h06050403));
    exp_q.push_back(mk(1, 4'b0001, 32'h00000007));
    exp_q.push_back(mk(0, 4'b0001, 32'h00000008));
    exp_q.push_back(mk(1, 4'b0001, 32'h00000009));
    push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 1); push_byte(0, 8'h08, 1);
    push_byte(1, 8'h03, 0); push_byte(1, 8'h04, 0); push_byte(1, 8'h05, 0);
    push_byte(1, 8'h06, 0); push_byte(1, 8'h07, 1); push_byte(1, 8'h09, 1);
    wait_idle("rr");

    // ERR on the first write of a 6-byte message: drain the rest.
    err_next = 1'b1;
    exp_q.push_back(mk(1, 4'b1111, 32'h13121110));
    for (int i = 0; i < 6; i++) push_byte(1, 8'(8'h10 + i), i == 5);
    wait_idle("err");
    chk("err_pulse_count", 64'(err_seen), 64'd1);

    // Reset while collecting after 2 bytes.
    push_byte(0, 8'h55, 0); push_byte(0, 8'h66, 0);
    begin
      int n;
      n = 0;
      while (n < 100 && src0.size() != 0) begin
        @(negedge clk_i);
        n++;
      end
      chk("partial_bytes_taken", 64'(n < 100), 64'd1);
    end
    @(negedge clk_i);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("mid_rst_cyc",       64'(CYC),       64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_busy",      64'(busy),      64'd0);
    exp_q.push_back(mk(1, 4'b1111, 32'hAA998877));
    push_byte(1, 8'h77, 0); push_byte(1, 8'h88, 0);
    push_byte(1, 8'h99, 0); push_byte(1, 8'hAA, 1);
    wait_idle("after_rst");
    chk("rst_no_err_pulse", 64'(err_seen), 64'd1);

    // Wait-stated ACK: data and SEL must stay stable across every cycle.
    ack_wait = 2;
    exp_q.push_back(mk(0, 4'b0011, 32'h0000ADDE));
    exp_q.push_back(mk(0, 4'b0001, 32'h000000BE));
    push_byte(0, 8'hDE, 0); push_byte(0, 8'hAD, 0); push_byte(0, 8'hBE, 1);
    wait_idle("wait_ack");
    chk("wait_ack_cyc_len", 64'(last_cyc_len), 64'd3);
    ack_wait = 0;

`ifdef WB_VMON_SEQ_TIMEOUT_EN
    // No ACK at all: the write is abandoned after 8 cycles.
    ack_en = 1'b0;
    exp_q.push_back(mk(1, 4'b1111, 32'h04030201));
    push_byte(1, 8'h01, 0); push_byte(1, 8'h02, 0);
    push_byte(1, 8'h03, 0); push_byte(1, 8'h04, 1);
    wait_idle("timeout");
    chk("timeout_cyc_len", 64'(last_cyc_len), 64'd8);
    chk("timeout_err_pulse", 64'(err_seen), 64'd2);
    ack_en = 1'b1;
`endif

    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
